sdio_data_sequencer: RTL and testbench
======================================

Name: sdio_data_sequencer

Overview:
- Transfer-level controller that sequences the SD data PHY for one CMD53 transfer: byte mode (one burst) or block mode (N blocks, or unbounded until abort).
- Drives the PHY activate / write-flag / byte-count handshake per block and waits for the function layer to be ready between blocks.
- Checks write CRC, enforces a per-block timeout and reports completion status to the command layer.

Parameters:
GAP_CYCLES, 4, idle clk_x2 cycles between PHY release and the next block's activate (min 1)
TIMEOUT_CYCLES, 24'hFFFFFF, max clk_x2 cycles activate may stay high without i_phy_finished

Ports:
clk_x2  in  1  sequencer clock (2x SD clock, synchronous to PHY clk)
rst  in  1  reset, synchronous, active-high
i_xfer_req  in  1  one-cycle start pulse; ignored while o_xfer_busy
i_xfer_write  in  1  1 = host-to-card write, 0 = card-to-host read
i_block_mode  in  1  1 = block mode, 0 = byte mode
i_count  in  9  CMD53 count field (blocks or bytes)
i_block_size  in  12  function block size in bytes; 0 = invalid
i_abort  in  1  abort request (CMD52 I/O abort), level
i_func_rdy  in  1  function can source/sink the next block
o_xfer_busy  out  1  transfer in progress
o_xfer_done  out  1  one-cycle completion pulse
o_err_code  out  2  valid with o_xfer_done: 0 ok, 1 crc, 2 timeout, 3 abort/invalid
o_blocks_done  out  9  blocks completed in current transfer (wraps)
o_phy_activate  out  1  PHY activate
o_phy_write_flag  out  1  PHY direction
o_phy_data_count  out  13  PHY byte count for current block
i_phy_finished  in  1  PHY finished level
i_phy_crc_good  in  1  PHY CRC result, valid while i_phy_finished

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-transfer drops o_phy_activate on the next edge; no done pulse is issued.
- All outputs are registered.
- IDLE:
  - On i_xfer_req, latch write, mode, count and size.
  - Clear o_blocks_done and o_err_code; set o_xfer_busy; go to WAIT_RDY.
- Byte count per burst:
  - Byte mode: i_count, with 0 meaning 512.
  - Block mode: i_block_size zero-extended to 13 bits.
  - Block mode with i_block_size == 0: go straight to DONE with err 3.
- Remaining-blocks counter (10 bits):
  - Byte mode: 1.
  - Block mode, count != 0: count.
  - Block mode, count == 0: unbounded; the counter never decrements and the transfer ends only on abort or error.
- WAIT_RDY: when i_func_rdy = 1 and i_phy_finished = 0, assert o_phy_activate and drive write_flag/data_count; go to ACTIVE. Result: activate rises 2 cycles after the req edge when func_rdy is already high.
- ACTIVE:
  - Hold activate, write_flag and data_count stable.
  - Timeout counter increments each cycle. Reaching TIMEOUT_CYCLES: err 2, go to RELEASE.
  - On i_phy_finished = 1:
    - Write with i_phy_crc_good = 0: err 1, go to RELEASE.
    - Otherwise increment o_blocks_done, decrement remaining (if bounded), go to RELEASE.
  - Read transfers ignore i_phy_crc_good.
- RELEASE:
  - Deassert activate; wait for i_phy_finished = 0.
  - Then: error set, or remaining reached 0 -> DONE; else -> GAP.
- GAP: count GAP_CYCLES cycles with activate low, then go to WAIT_RDY.
- DONE: pulse o_xfer_done for one cycle; clear o_xfer_busy in the same cycle; return to IDLE.
- Abort, in any busy state:
  - Set err 3 (unless an error is already latched) and deassert activate next cycle.
  - Go to RELEASE if activate was high, else to DONE.
- Abort in the same cycle as i_phy_finished: abort wins and the block is not counted.
- Error priority: first latched error is kept.
- i_xfer_req while busy: ignored, no state change.
- o_blocks_done wraps 511 -> 0 in unbounded mode.

Test Plan:
- Byte-mode read, count=0: activate rises 2 cycles after req, data_count=512; finished -> RELEASE; done with err 0, blocks_done=1.
- Block-mode write, count=3, size=64, crc_good=1: three activate pulses, each data_count=64, separated by at least 4 idle cycles; done with err 0, blocks_done=3.
- Block-mode write, count=4, crc_good=0 on block 2: stops after block 2; done with err 1, blocks_done=1.
- Unbounded block read (count=0): after 5 blocks assert i_abort mid-block -> activate drops next cycle; after finished falls, done with err 3, blocks_done=5.
- TIMEOUT_CYCLES=100, finished never asserted: at cycle 100 in ACTIVE, activate drops; done with err 2. Also block size=0 in block mode -> immediate done with err 3 and no activate.
- i_func_rdy held low for 20 cycles and a second i_xfer_req while busy: activate waits for func_rdy; the second req has no effect; rst mid-ACTIVE clears all outputs with no done pulse.

Source files
------------

// File: rtl/sdio_data_sequencer.sv
// CMD53 transfer sequencer: runs the SD data PHY one burst (byte mode) or one
// block at a time (block mode), checks write CRC, times out stuck blocks and reports status.
module sdio_data_sequencer #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        clk_x2,
    input  logic        rst,
    input  logic        i_xfer_req,
    input  logic        i_xfer_write,
    input  logic        i_block_mode,
    input  logic [8:0]  i_count,
    input  logic [11:0] i_block_size,
    input  logic        i_abort,
    input  logic        i_func_rdy,
    output logic        o_xfer_busy,
    output logic        o_xfer_done,
    output logic [1:0]  o_err_code,
    output logic [8:0]  o_blocks_done,
    output logic        o_phy_activate,
    output logic        o_phy_write_flag,
    output logic [12:0] o_phy_data_count,
    input  logic        i_phy_finished,
    input  logic        i_phy_crc_good
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_ACTIVE, S_RELEASE, S_GAP, S_DONE
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [23:0]      TMO_LIMIT = 24'(TIMEOUT_CYCLES);

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_CRC   = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    state_t             r_state, w_state_nxt;
    logic               r_write, w_write_nxt;
    logic               r_unbounded, w_unbounded_nxt;
    logic [9:0]         r_remaining, w_remaining_nxt;
    logic [12:0]        r_burst, w_burst_nxt;
    logic [23:0]        r_tmo, w_tmo_nxt;
    logic [GAP_W-1:0]   r_gap, w_gap_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [1:0]         r_err, w_err_nxt;
    logic [8:0]         r_blocks_done, w_blocks_done_nxt;
    logic               r_act, w_act_nxt;
    logic               r_wflag, w_wflag_nxt;
    logic [12:0]        r_dcount, w_dcount_nxt;
    logic [23:0]        w_tmo_inc;

    assign w_tmo_inc = r_tmo + 24'd1;

    // PHY handshake: activate (with write_flag/data_count stable) requests one burst;
    // the PHY answers with finished held high until it sees activate low.
    always_comb begin
        w_state_nxt       = r_state;
        w_write_nxt       = r_write;
        w_unbounded_nxt   = r_unbounded;
        w_remaining_nxt   = r_remaining;
        w_burst_nxt       = r_burst;
        w_tmo_nxt         = r_tmo;
        w_gap_nxt         = r_gap;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_err_nxt         = r_err;
        w_blocks_done_nxt = r_blocks_done;
        w_act_nxt         = r_act;
        w_wflag_nxt       = r_wflag;
        w_dcount_nxt      = r_dcount;

        case (r_state)
            S_IDLE: begin
                if (i_xfer_req) begin
                    w_write_nxt       = i_xfer_write;
                    w_unbounded_nxt   = i_block_mode && (i_count == 9'd0);
                    w_remaining_nxt   = i_block_mode ? {1'b0, i_count} : 10'd1;
                    w_burst_nxt       = i_block_mode ? {1'b0, i_block_size}
                                      : (i_count == 9'd0) ? 13'd512 : {4'd0, i_count};
                    w_blocks_done_nxt = 9'd0;
                    w_busy_nxt        = 1'b1;
                    if (i_block_mode && i_block_size == 12'd0) begin
                        w_err_nxt   = ERR_ABORT;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_err_nxt   = ERR_OK;
                        w_state_nxt = S_WAIT_RDY;
                    end
                end
            end
            S_WAIT_RDY: begin
                if (i_abort) begin
                    if (r_err == ERR_OK) w_err_nxt = ERR_ABORT;
                    w_state_nxt = S_DONE;
                end else if (i_func_rdy && !i_phy_finished) begin
                    w_act_nxt    = 1'b1;
                    w_wflag_nxt  = r_write;
                    w_dcount_nxt = r_burst;
                    w_tmo_nxt    = 24'd0;
                    w_state_nxt  = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                w_tmo_nxt = w_tmo_inc;
                // Abort outranks a finish in the same cycle, so that block is not counted.
                if (i_abort) begin
                    if (r_err == ERR_OK) w_err_nxt = ERR_ABORT;
                    w_act_nxt   = 1'b0;
                    w_state_nxt = S_RELEASE;
                end else if (i_phy_finished) begin
                    w_act_nxt   = 1'b0;
                    w_state_nxt = S_RELEASE;
                    if (r_write && !i_phy_crc_good) begin
                        if (r_err == ERR_OK) w_err_nxt = ERR_CRC;
                    end else begin
                        w_blocks_done_nxt = r_blocks_done + 9'd1;
                        if (!r_unbounded) w_remaining_nxt = r_remaining - 10'd1;
                    end
                end else if (w_tmo_inc == TMO_LIMIT) begin
                    if (r_err == ERR_OK) w_err_nxt = ERR_TMO;
                    w_act_nxt   = 1'b0;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (i_abort && r_err == ERR_OK) w_err_nxt = ERR_ABORT;
                if (!i_phy_finished) begin
                    if (w_err_nxt != ERR_OK || (!r_unbounded && r_remaining == 10'd0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_gap_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (i_abort) begin
                    if (r_err == ERR_OK) w_err_nxt = ERR_ABORT;
                    w_state_nxt = S_DONE;
                end else if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_WAIT_RDY;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_x2) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_unbounded   <= 1'b0;
            r_remaining   <= 10'd0;
            r_burst       <= 13'd0;
            r_tmo         <= 24'd0;
            r_gap         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= ERR_OK;
            r_blocks_done <= 9'd0;
            r_act         <= 1'b0;
            r_wflag       <= 1'b0;
            r_dcount      <= 13'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_write       <= w_write_nxt;
            r_unbounded   <= w_unbounded_nxt;
            r_remaining   <= w_remaining_nxt;
            r_burst       <= w_burst_nxt;
            r_tmo         <= w_tmo_nxt;
            r_gap         <= w_gap_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_blocks_done <= w_blocks_done_nxt;
            r_act         <= w_act_nxt;
            r_wflag       <= w_wflag_nxt;
            r_dcount      <= w_dcount_nxt;
        end
    end

    assign o_xfer_busy      = r_busy;
    assign o_xfer_done      = r_done;
    assign o_err_code       = r_err;
    assign o_blocks_done    = r_blocks_done;
    assign o_phy_activate   = r_act;
    assign o_phy_write_flag = r_wflag;
    assign o_phy_data_count = r_dcount;

endmodule

// File: tb/tb_sdio_data_sequencer.sv
// Bench for sdio_data_sequencer: table of directed transfers, hand sequences for
// reset corners, and random transfers predicted by a block-level reference model.
module tb_sdio_data_sequencer;

    localparam int GAP = 4;
    localparam int TMO = 100;

    logic        clk_x2 = 1'b0;
    logic        rst;
    logic        i_xfer_req, i_xfer_write, i_block_mode, i_abort, i_func_rdy;
    logic [8:0]  i_count;
    logic [11:0] i_block_size;
    logic        i_phy_finished, i_phy_crc_good;
    logic        o_xfer_busy, o_xfer_done, o_phy_activate, o_phy_write_flag;
    logic [1:0]  o_err_code;
    logic [8:0]  o_blocks_done;
    logic [12:0] o_phy_data_count;

    int tests = 0;
    int fails = 0;
    logic [12:0] exp_q[$];

    typedef struct {
        bit wr; bit bm; int cnt; int sz; int crc_bad; int abort_blk; int lat;
        int rdy_delay; bit dup;
        int exp_err; int exp_blocks; int exp_pulses; int exp_bytes; int exp_lat;
    } vec_t;

    vec_t tbl[12];

    sdio_data_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_x2(clk_x2), .rst(rst),
        .i_xfer_req(i_xfer_req), .i_xfer_write(i_xfer_write), .i_block_mode(i_block_mode),
        .i_count(i_count), .i_block_size(i_block_size), .i_abort(i_abort),
        .i_func_rdy(i_func_rdy), .o_xfer_busy(o_xfer_busy), .o_xfer_done(o_xfer_done),
        .o_err_code(o_err_code), .o_blocks_done(o_blocks_done),
        .o_phy_activate(o_phy_activate), .o_phy_write_flag(o_phy_write_flag),
        .o_phy_data_count(o_phy_data_count), .i_phy_finished(i_phy_finished),
        .i_phy_crc_good(i_phy_crc_good)
    );

    // clock / reset
    always #5 clk_x2 = ~clk_x2;

    task automatic check(input string tag, input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, name, got, exp);
        end
    endtask

    function automatic vec_t mkv(bit wr, bit bm, int cnt, int sz, int crc_bad, int abort_blk,
                                 int lat, int rdy, bit dup, int e_err, int e_blk, int e_pul,
                                 int e_bytes, int e_lat);
        vec_t v;
        v.wr = wr; v.bm = bm; v.cnt = cnt; v.sz = sz; v.crc_bad = crc_bad;
        v.abort_blk = abort_blk; v.lat = lat; v.rdy_delay = rdy; v.dup = dup;
        v.exp_err = e_err; v.exp_blocks = e_blk; v.exp_pulses = e_pul;
        v.exp_bytes = e_bytes; v.exp_lat = e_lat;
        return v;
    endfunction

    // Block-by-block outcome of a transfer from the transfer rules alone.
    function automatic void model(inout vec_t v);
        int target;
        v.exp_bytes  = v.bm ? v.sz : ((v.cnt == 0) ? 512 : v.cnt);
        v.exp_lat    = (v.rdy_delay > 1) ? v.rdy_delay + 1 : 2;
        v.exp_err    = 0;
        v.exp_blocks = 0;
        v.exp_pulses = 0;
        if (v.bm && v.sz == 0) begin
            v.exp_err = 3;
            return;
        end
        target = v.bm ? v.cnt : 1;
        for (int k = 0; k < 2000; k++) begin
            v.exp_pulses = k + 1;
            if (v.abort_blk == k)              begin v.exp_err = 3; v.exp_blocks = k % 512; return; end
            if (v.lat == 0)                    begin v.exp_err = 2; v.exp_blocks = k % 512; return; end
            if (v.wr && v.crc_bad == k)        begin v.exp_err = 1; v.exp_blocks = k % 512; return; end
            if (target != 0 && k + 1 == target) begin v.exp_blocks = (k + 1) % 512; return; end
        end
    endfunction

    // driver + PHY responder + scoreboard for one transfer; starts and ends on a negedge
    task automatic run_xfer(input vec_t v, input string tag);
        int ac, pulses, first_lat, low_run, last_high, blk, err_got, blk_got;
        bit prev_act, got_done, abort_chk, fin;
        logic [12:0] e;
        for (int i = 0; i < v.exp_pulses; i++) exp_q.push_back(13'(v.exp_bytes));
        i_xfer_write = v.wr; i_block_mode = v.bm; i_count = 9'(v.cnt);
        i_block_size = 12'(v.sz); i_xfer_req = 1'b1; i_func_rdy = (v.rdy_delay == 0);
        prev_act = 0; pulses = 0; ac = 0; first_lat = -1; low_run = 0; last_high = 0;
        got_done = 0; abort_chk = 0; fin = 0; err_got = -1; blk_got = -1;
        for (int cyc = 1; cyc <= 20000 && !got_done; cyc++) begin
            @(negedge clk_x2);
            i_xfer_req = 1'b0;
            i_abort    = 1'b0;
            if (cyc == 1) check(tag, "busy_after_req", int'(o_xfer_busy), 1);
            if (v.dup && cyc == 3) begin
                i_xfer_req = 1'b1; i_xfer_write = !v.wr; i_block_mode = 1'b1;
                i_count = 9'd2; i_block_size = 12'd100;
            end
            if (cyc == v.rdy_delay) i_func_rdy = 1'b1;
            if (abort_chk) begin
                check(tag, "abort_drop", int'(o_phy_activate), 0);
                abort_chk = 0;
            end
            if (o_phy_activate && !prev_act) begin
                if (pulses == 0) first_lat = cyc;
                else check(tag, "gap", low_run, GAP + 2);
                pulses++;
                ac = 0;
                check(tag, "wflag", int'(o_phy_write_flag), int'(v.wr));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(tag, "data_count", int'(o_phy_data_count), int'(e));
                end else begin
                    check(tag, "extra_pulse", pulses, v.exp_pulses);
                end
            end
            if (o_phy_activate) begin
                ac++;
                low_run = 0;
                blk = pulses - 1;
                if (v.abort_blk == blk && ac == 1) begin i_abort = 1'b1; abort_chk = 1; end
                if (v.lat != 0 && ac == v.lat) begin
                    fin = 1;
                    i_phy_crc_good = (blk != v.crc_bad);
                end
            end else begin
                if (prev_act) last_high = ac;
                low_run++;
                fin = 0;
            end
            i_phy_finished = fin;
            if (o_xfer_done) begin
                got_done = 1;
                err_got  = int'(o_err_code);
                blk_got  = int'(o_blocks_done);
                check(tag, "busy_at_done", int'(o_xfer_busy), 0);
            end
            prev_act = o_phy_activate;
        end
        i_abort = 1'b0;
        i_phy_finished = 1'b0;
        check(tag, "done_seen", int'(got_done), 1);
        check(tag, "err", err_got, v.exp_err);
        check(tag, "blocks_done", blk_got, v.exp_blocks);
        check(tag, "pulses", pulses, v.exp_pulses);
        if (v.exp_pulses > 0) check(tag, "first_act_lat", first_lat, v.exp_lat);
        if (v.exp_err == 2) check(tag, "timeout_len", last_high, TMO);
        check(tag, "scoreboard_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk_x2);
        check(tag, "done_one_cycle", int'(o_xfer_done), 0);
        @(negedge clk_x2);
        @(negedge clk_x2);
        check(tag, "idle_after", int'({o_phy_activate, o_xfer_busy}), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "busy", int'(o_xfer_busy), 0);
        check(tag, "done", int'(o_xfer_done), 0);
        check(tag, "err", int'(o_err_code), 0);
        check(tag, "blocks_done", int'(o_blocks_done), 0);
        check(tag, "activate", int'(o_phy_activate), 0);
        check(tag, "write_flag", int'(o_phy_write_flag), 0);
        check(tag, "data_count", int'(o_phy_data_count), 0);
    endtask

    task automatic reset_mid_active();
        int seen, dones;
        i_xfer_write = 1'b1; i_block_mode = 1'b0; i_count = 9'd10; i_block_size = 12'd0;
        i_func_rdy = 1'b1; i_xfer_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_x2);
            i_xfer_req = 1'b0;
            if (o_phy_activate) seen = 1;
        end
        check("rst_mid", "act_seen", seen, 1);
        check("rst_mid", "dcount_before", int'(o_phy_data_count), 10);
        @(negedge clk_x2);
        @(negedge clk_x2);
        rst = 1'b1;
        @(negedge clk_x2);
        rst = 1'b0;
        check_all_zero("rst_mid");
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_x2);
            if (o_xfer_done || o_phy_activate) dones++;
        end
        check("rst_mid", "quiet_after", dones, 0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; i_xfer_req = 0; i_xfer_write = 0; i_block_mode = 0; i_count = 0;
        i_block_size = 0; i_abort = 0; i_func_rdy = 0; i_phy_finished = 0; i_phy_crc_good = 0;
        repeat (3) @(negedge clk_x2);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk_x2);

        //             wr bm cnt  sz    crc abrt lat rdy dup err blk pul bytes lat
        tbl[0]  = mkv(0, 0, 0,   0,    -1, -1,  3,  0,  0,  0,  1,  1,  512,  2);
        tbl[1]  = mkv(1, 1, 3,   64,   -1, -1,  2,  0,  0,  0,  3,  3,  64,   2);
        tbl[2]  = mkv(1, 1, 4,   64,    1, -1,  2,  0,  0,  1,  1,  2,  64,   2);
        tbl[3]  = mkv(0, 1, 0,   32,   -1,  5,  4,  0,  0,  3,  5,  6,  32,   2);
        tbl[4]  = mkv(0, 1, 2,   16,   -1, -1,  0,  0,  0,  2,  0,  1,  16,   2);
        tbl[5]  = mkv(1, 1, 3,   0,    -1, -1,  2,  0,  0,  3,  0,  0,  0,    2);
        tbl[6]  = mkv(1, 0, 7,   200,  -1, -1,  3,  20, 1,  0,  1,  1,  7,    21);
        tbl[7]  = mkv(1, 0, 511, 0,     0, -1,  2,  0,  0,  1,  0,  1,  511,  2);
        tbl[8]  = mkv(0, 1, 0,   8,    -1, 513, 1,  0,  0,  3,  1,  514, 8,   2);
        tbl[9]  = mkv(0, 1, 3,   128,  -1,  1,  1,  0,  0,  3,  1,  2,  128,  2);
        tbl[10] = mkv(1, 1, 1,   4095, -1, -1,  5,  0,  0,  0,  1,  1,  4095, 2);
        tbl[11] = mkv(0, 1, 2,   20,    0, -1,  2,  0,  0,  0,  2,  2,  20,   2);

        for (int i = 0; i < 12; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

        reset_mid_active();

        for (int i = 0; i < 25; i++) begin
            v = mkv(0, 0, 0, 0, -1, -1, 1, 0, 0, 0, 0, 0, 0, 2);
            v.wr  = 1'($urandom_range(0, 1));
            v.bm  = 1'($urandom_range(0, 1));
            v.cnt = v.bm ? $urandom_range(0, 4) : $urandom_range(0, 511);
            v.sz  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 700);
            v.lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            v.rdy_delay = $urandom_range(0, 5);
            v.crc_bad   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            if (v.bm && v.cnt == 0) v.abort_blk = $urandom_range(0, 4);
            else if ($urandom_range(0, 3) == 0) v.abort_blk = $urandom_range(0, 3);
            v.dup = !(v.bm && v.sz == 0) && ($urandom_range(0, 3) == 0);
            model(v);
            run_xfer(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
